// File: rtl/dram_cmd_checker.sv
// DRAM-side command checker/responder: per-bank open state and timers, timing violation
// reporting, and read/write data-window strobes. Optional refresh watchdog: DRAM_CHK_REFRESH_EN.
module dram_cmd_checker #(
  parameter int NBANK     = 4,
  parameter int N         = 10,
  parameter int tRCD      = 10,
  parameter int tRP       = 10,
  parameter int tRAS      = 28,
  parameter int tRL       = 10,
  parameter int tWL       = 8,
  parameter int tBURST    = 4,
  parameter int tWR       = 12,
  parameter int tRFC      = 160,
  parameter int tREFI     = 780,
  parameter int REF_LIMIT = 9 * tREFI
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     cmd_valid,
  input  logic [2:0]               cmd,
  input  logic [$clog2(NBANK)-1:0] cmd_bank,
  output logic [NBANK-1:0]         bank_open,
  output logic                     rd_valid,
  output logic                     wr_window,
  output logic                     viol,
  output logic [3:0]               viol_code,
  output logic [7:0]               viol_count,
  output logic                     ref_overdue
);

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_PREA = 3'd5,
    CMD_REF  = 3'd6,
    CMD_RSVD = 3'd7
  } cmd_e;

  typedef enum logic [3:0] {
    V_NONE     = 4'd0,
    V_TRFC     = 4'd1,
    V_ACT_OPEN = 4'd2,
    V_TRP      = 4'd3,
    V_NOT_OPEN = 4'd4,
    V_TRCD     = 4'd5,
    V_TCCD     = 4'd6,
    V_TRAS     = 4'd7,
    V_TWR      = 4'd8,
    V_REF_OPEN = 4'd9
  } viol_e;

  // Timers hold "cycles still to wait" after the loading command's own cycle.
  localparam logic [N-1:0] RCD_LD = N'(tRCD - 1);
  localparam logic [N-1:0] RAS_LD = N'(tRAS - 1);
  localparam logic [N-1:0] RP_LD  = N'(tRP - 1);
  localparam logic [N-1:0] WR_LD  = N'(tWL + tBURST + tWR - 1);
  localparam logic [N-1:0] RFC_LD = N'(tRFC - 1);
  localparam logic [N-1:0] CCD_LD = N'(tBURST - 1);

  localparam int RD_LEN = tRL + tBURST - 1;
  localparam int WR_LEN = tWL + tBURST - 1;

  function automatic logic [N-1:0] dec(input logic [N-1:0] v);
    return (v == '0) ? v : v - N'(1);
  endfunction

  cmd_e         op;
  viol_e        code;
  logic [N-1:0] trcd_q [NBANK];
  logic [N-1:0] tras_q [NBANK];
  logic [N-1:0] trp_q  [NBANK];
  logic [N-1:0] twr_q  [NBANK];
  logic [N-1:0] trfc_q;
  logic [N-1:0] ccd_q;
  logic [NBANK-1:0] sel;
  logic         any_open;
  logic         tras_busy_open;
  logic         twr_busy_open;
  logic         accept;
  logic         acc_act, acc_rd, acc_wr, acc_pre, acc_prea, acc_ref;
  logic [RD_LEN-1:0] rd_line;
  logic [WR_LEN-1:0] wr_line;

  assign op       = cmd_e'(cmd);
  assign any_open = |bank_open;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    sel            = '0;
    sel[cmd_bank]  = 1'b1;
    tras_busy_open = 1'b0;
    twr_busy_open  = 1'b0;
    for (int i = 0; i < NBANK; i++) begin
      tras_busy_open = tras_busy_open | (bank_open[i] && (tras_q[i] != '0));
      twr_busy_open  = twr_busy_open  | (bank_open[i] && (twr_q[i]  != '0));
    end
  end

  // First matching rule wins; the order of the branches is the priority order.
  always_comb begin
    code = V_NONE;
    if (cmd_valid && op != CMD_NOP && op != CMD_RSVD) begin
      if (trfc_q != '0) begin
        code = V_TRFC;
      end else begin
        case (op)
          CMD_ACT: begin
            if (bank_open[cmd_bank])           code = V_ACT_OPEN;
            else if (trp_q[cmd_bank] != '0)    code = V_TRP;
          end
          CMD_RD, CMD_WR: begin
            if (!bank_open[cmd_bank])          code = V_NOT_OPEN;
            else if (trcd_q[cmd_bank] != '0)   code = V_TRCD;
            else if (ccd_q != '0)              code = V_TCCD;
          end
          CMD_PRE: begin
            if (tras_q[cmd_bank] != '0)        code = V_TRAS;
            else if (twr_q[cmd_bank] != '0)    code = V_TWR;
          end
          CMD_PREA: begin
            if (tras_busy_open)                code = V_TRAS;
            else if (twr_busy_open)            code = V_TWR;
          end
          CMD_REF: begin
            if (any_open)                      code = V_REF_OPEN;
          end
          default: code = V_NONE;
        endcase
      end
    end
  end

  assign accept   = cmd_valid && (code == V_NONE);
  assign acc_act  = accept && (op == CMD_ACT);
  assign acc_rd   = accept && (op == CMD_RD);
  assign acc_wr   = accept && (op == CMD_WR);
  assign acc_pre  = accept && (op == CMD_PRE);
  assign acc_prea = accept && (op == CMD_PREA);
  assign acc_ref  = accept && (op == CMD_REF);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      bank_open  <= '0;
      trfc_q     <= '0;
      ccd_q      <= '0;
      viol       <= 1'b0;
      viol_code  <= 4'd0;
      viol_count <= 8'd0;
      rd_line    <= '0;
      wr_line    <= '0;
      // NOTE: the per-bank timer arrays are plain flops, not RAM, so they take the reset too.
      for (int i = 0; i < NBANK; i++) begin
        trcd_q[i] <= '0;
        tras_q[i] <= '0;
        trp_q[i]  <= '0;
        twr_q[i]  <= '0;
      end
    end else begin
      viol <= (code != V_NONE);
      if (code != V_NONE) begin
        viol_code <= code;
        if (viol_count != 8'hFF) viol_count <= viol_count + 8'd1;
      end

      trfc_q <= acc_ref ? RFC_LD : dec(trfc_q);
      ccd_q  <= (acc_rd || acc_wr) ? CCD_LD : dec(ccd_q);

      for (int i = 0; i < NBANK; i++) begin
        trcd_q[i] <= dec(trcd_q[i]);
        tras_q[i] <= dec(tras_q[i]);
        trp_q[i]  <= dec(trp_q[i]);
        twr_q[i]  <= dec(twr_q[i]);
        if (acc_act && sel[i]) begin
          bank_open[i] <= 1'b1;
          trcd_q[i]    <= RCD_LD;
          tras_q[i]    <= RAS_LD;
        end
        // PRE to a closed bank is a silent no-op.
        if (bank_open[i] && ((acc_pre && sel[i]) || acc_prea)) begin
          bank_open[i] <= 1'b0;
          trp_q[i]     <= RP_LD;
        end
        if (acc_wr && sel[i]) twr_q[i] <= WR_LD;
      end

      rd_line <= {rd_line[RD_LEN-2:0], acc_rd};
      wr_line <= {wr_line[WR_LEN-2:0], acc_wr};
    end
  end

  // Bit k of a delay line is set k+1 cycles after the accepted command.
  assign rd_valid  = |rd_line[RD_LEN-1:tRL-1];
  assign wr_window = |wr_line[WR_LEN-1:tWL-1];

`ifdef DRAM_CHK_REFRESH_EN
  localparam int RCW = $clog2(REF_LIMIT + 1);

  logic [RCW-1:0] ref_cnt;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      ref_cnt     <= '0;
      ref_overdue <= 1'b0;
    end else if (acc_ref) begin
      ref_cnt     <= '0;
      ref_overdue <= 1'b0;
    end else begin
      if (ref_cnt != '1) ref_cnt <= ref_cnt + RCW'(1);
      // Sticky, so a counter whose maximum equals REF_LIMIT still reports.
      if (ref_cnt >= RCW'(REF_LIMIT)) ref_overdue <= 1'b1;
    end
  end
`else
  localparam int unused_ref_limit = REF_LIMIT;

  assign ref_overdue = 1'b0;
`endif

endmodule
